ioctl_loader: RTL and testbench

IOCTL_LOADER -- requirements
Module: ioctl_loader

---
 rtl/ioctl_loader_pkg.sv | 34 +++
 rtl/ioctl_loader_if.sv | 63 ++++++
 rtl/ioctl_loader.sv | 217 +++++++++++++++++++++
 tb/tb_ioctl_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_loader_pkg.sv
// ioctl_loader_pkg: shared types and default constants for the ioctl loader.
//   state_e       - loader FSM states
//   ioctl_word_t  - captured hps_io word (byte address + 16-bit data)
//   DEF_*         - default INDEX / ADDR_W / POST_HOLD values
//   byte_in_range - true when a byte address fits the target memory
package ioctl_loader_pkg;

  localparam logic [7:0]  DEF_INDEX     = 8'd0;
  localparam int unsigned DEF_ADDR_W    = 12;
  localparam int unsigned DEF_POST_HOLD = 256;

  localparam int unsigned IOCTL_ADDR_W  = 25;
  localparam int unsigned IOCTL_DATA_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WR_LO,
    WR_HI,
    HOLD
  } state_e;

  typedef struct packed {
    logic [IOCTL_ADDR_W-1:0] addr;
    logic [IOCTL_DATA_W-1:0] dout;
  } ioctl_word_t;

  // A byte is writable only when no address bit at or above aw is set.
  function automatic logic byte_in_range(input logic [IOCTL_ADDR_W-1:0] addr,
                                         input int unsigned             aw);
    return (addr >> aw) == '0;
  endfunction

endpackage

// File: rtl/ioctl_loader_if.sv
// ioctl_loader_if: bundle between hps_io, the loader and the target memory.
//   ioctl_download/index/wr/addr/dout - download stream from hps_io
//   ioctl_wait                        - backpressure to hps_io
//   mem_addr/data/wr                  - 8-bit memory write port
//   copy_in_progress, cpu_reset_req   - load status / CPU hold request
//   bytes_loaded, overflow            - load statistics
// Modports: master = hps_io side (drives the download stream),
//           slave  = loader side.
interface ioctl_loader_if
  import ioctl_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic                    ioctl_download;
  logic [7:0]              ioctl_index;
  logic                    ioctl_wr;
  logic [IOCTL_ADDR_W-1:0] ioctl_addr;
  logic [IOCTL_DATA_W-1:0] ioctl_dout;
  logic                    ioctl_wait;

  logic [ADDR_W-1:0]       mem_addr;
  logic [7:0]              mem_data;
  logic                    mem_wr;

  logic                    copy_in_progress;
  logic                    cpu_reset_req;
  logic [ADDR_W:0]         bytes_loaded;
  logic                    overflow;

  modport master (
    output ioctl_download,
    output ioctl_index,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_dout,
    input  ioctl_wait,
    input  mem_addr,
    input  mem_data,
    input  mem_wr,
    input  copy_in_progress,
    input  cpu_reset_req,
    input  bytes_loaded,
    input  overflow
  );

  modport slave (
    input  ioctl_download,
    input  ioctl_index,
    input  ioctl_wr,
    input  ioctl_addr,
    input  ioctl_dout,
    output ioctl_wait,
    output mem_addr,
    output mem_data,
    output mem_wr,
    output copy_in_progress,
    output cpu_reset_req,
    output bytes_loaded,
    output overflow
  );

endinterface

// File: rtl/ioctl_loader.sv
// ioctl_loader: turns the 16-bit hps_io download stream into byte writes on
// an 8-bit memory port, holding the CPU in reset while loading and for
// POST_HOLD cycles afterwards.
//   clk_sys - single clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - ioctl_loader_if.slave: download stream in, ioctl_wait out,
//             memory write port and status outputs out
// Every output is a register; each is loaded from the value the next state
// calls for, so outputs line up with the state they belong to.
module ioctl_loader
  import ioctl_loader_pkg::*;
#(
  parameter logic [7:0]  INDEX     = DEF_INDEX,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned POST_HOLD = DEF_POST_HOLD
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  ioctl_loader_if.slave bus
);

  localparam int unsigned       CNT_W     = (POST_HOLD > 1) ? $clog2(POST_HOLD) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(POST_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   BYTES_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   BYTES_ONE = (ADDR_W + 1)'(1);

  // State and captured word
  state_e                  r_state;
  ioctl_word_t             r_word;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_dl_prev;

  // Registered outputs
  logic                    r_wait;
  logic [ADDR_W-1:0]       r_mem_addr;
  logic [7:0]              r_mem_data;
  logic                    r_mem_wr;
  logic                    r_cip;
  logic                    r_rst_req;
  logic [ADDR_W:0]         r_bytes;
  logic                    r_ovf;

  // Next-state values
  state_e                  w_state_nxt;
  ioctl_word_t             w_word_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_wait_nxt;
  logic [ADDR_W-1:0]       w_mem_addr_nxt;
  logic [7:0]              w_mem_data_nxt;
  logic                    w_mem_wr_nxt;
  logic                    w_cip_nxt;
  logic                    w_rst_req_nxt;
  logic [ADDR_W:0]         w_bytes_nxt;
  logic                    w_ovf_nxt;

  // Byte slot being issued in the next cycle
  logic                    w_slot;
  logic [IOCTL_ADDR_W-1:0] w_slot_addr;
  logic [7:0]              w_slot_data;

  // A load starts only on a fresh rise of ioctl_download with our index;
  // r_dl_prev resets high so a download held through reset is not taken.
  logic                    w_start;
  assign w_start = bus.ioctl_download && !r_dl_prev && (bus.ioctl_index == INDEX);

  // State and output registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_cnt      <= '0;
      r_dl_prev  <= 1'b1;
      r_wait     <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_wr   <= 1'b0;
      r_cip      <= 1'b0;
      r_rst_req  <= 1'b0;
      r_bytes    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dl_prev  <= bus.ioctl_download;
      r_wait     <= w_wait_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_data <= w_mem_data_nxt;
      r_mem_wr   <= w_mem_wr_nxt;
      r_cip      <= w_cip_nxt;
      r_rst_req  <= w_rst_req_nxt;
      r_bytes    <= w_bytes_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_cnt_nxt      = r_cnt;
    w_wait_nxt     = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_data_nxt = r_mem_data;
    w_mem_wr_nxt   = 1'b0;
    w_cip_nxt      = 1'b0;
    w_rst_req_nxt  = 1'b0;
    w_bytes_nxt    = r_bytes;
    w_ovf_nxt      = r_ovf;
    w_slot         = 1'b0;
    w_slot_addr    = '0;
    w_slot_data    = '0;

    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = ARMED;
          w_bytes_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      ARMED: begin
        // A strobe in the same cycle download drops still completes its word.
        if (bus.ioctl_wr) begin
          w_state_nxt     = WR_LO;
          w_word_nxt.addr = bus.ioctl_addr;
          w_word_nxt.dout = bus.ioctl_dout;
        end else if (!bus.ioctl_download) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
        end
      end
      WR_LO: begin
        w_state_nxt = WR_HI;
      end
      WR_HI: begin
        if (bus.ioctl_download) begin
          w_state_nxt = ARMED;
        end else begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (w_start) begin
          w_state_nxt = ARMED;
          w_bytes_nxt = '0;
          w_ovf_nxt   = 1'b0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Outputs belonging to the state about to be entered
    unique case (w_state_nxt)
      IDLE: begin
      end
      ARMED: begin
        w_cip_nxt     = 1'b1;
        w_rst_req_nxt = 1'b1;
      end
      WR_LO: begin
        w_cip_nxt     = 1'b1;
        w_rst_req_nxt = 1'b1;
        w_wait_nxt    = 1'b1;
        w_slot        = 1'b1;
        w_slot_addr   = w_word_nxt.addr;
        w_slot_data   = w_word_nxt.dout[7:0];
      end
      WR_HI: begin
        w_cip_nxt     = 1'b1;
        w_rst_req_nxt = 1'b1;
        w_wait_nxt    = 1'b1;
        w_slot        = 1'b1;
        w_slot_addr   = w_word_nxt.addr + IOCTL_ADDR_W'(1);
        w_slot_data   = w_word_nxt.dout[15:8];
      end
      HOLD: begin
        w_rst_req_nxt = 1'b1;
      end
      default: begin
      end
    endcase

    // Byte slot: write when in range, otherwise drop it and flag overflow.
    if (w_slot) begin
      w_mem_addr_nxt = w_slot_addr[ADDR_W-1:0];
      w_mem_data_nxt = w_slot_data;
      if (byte_in_range(w_slot_addr, ADDR_W)) begin
        w_mem_wr_nxt = 1'b1;
        if (r_bytes != BYTES_MAX) begin
          w_bytes_nxt = r_bytes + BYTES_ONE;
        end
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end
  end

  // Output drive
  assign bus.ioctl_wait       = r_wait;
  assign bus.mem_addr         = r_mem_addr;
  assign bus.mem_data         = r_mem_data;
  assign bus.mem_wr           = r_mem_wr;
  assign bus.copy_in_progress = r_cip;
  assign bus.cpu_reset_req    = r_rst_req;
  assign bus.bytes_loaded     = r_bytes;
  assign bus.overflow         = r_ovf;

endmodule

// File: tb/tb_ioctl_loader.sv
// tb_ioctl_loader: directed and randomized downloads into ioctl_loader,
// checked against a byte-level reference model of the expected writes.
module tb_ioctl_loader;

  localparam int unsigned AW        = 12;
  localparam int unsigned HOLD_CYC  = 256;
  localparam int unsigned MEM_BYTES = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ioctl_loader_if #(.ADDR_W(AW)) bus ();

  ioctl_loader #(
    .INDEX    (8'd0),
    .ADDR_W   (AW),
    .POST_HOLD(HOLD_CYC)
  ) dut (
    .clk_sys(clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observed and expected byte writes as {addr[11:0], data[7:0]}
  logic [19:0] obs_q[$];
  logic [19:0] exp_q[$];
  int          exp_bytes;
  logic        exp_ovf;

  always @(negedge clk) begin
    if (rst_n && bus.mem_wr) obs_q.push_back({bus.mem_addr, bus.mem_data});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a word is two bytes at a and a+1; a byte lands only
  // below MEM_BYTES, otherwise it is lost and overflow sticks.
  task automatic model_word(input logic [24:0] a, input logic [15:0] d);
    for (int k = 0; k < 2; k++) begin
      int unsigned ba;
      logic [7:0]  b;
      ba = int'(a) + k;
      b  = (k == 0) ? d[7:0] : d[15:8];
      if (ba < MEM_BYTES) begin
        exp_q.push_back({12'(ba), b});
        if (exp_bytes < int'(MEM_BYTES)) exp_bytes++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_wr%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag);
    check({tag, "_bytes"}, 32'(bus.bytes_loaded), 32'(exp_bytes));
    check({tag, "_ovf"},   32'(bus.overflow),     32'(exp_ovf));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wait"},  32'(bus.ioctl_wait),       32'd0);
    check({tag, "_maddr"}, 32'(bus.mem_addr),         32'd0);
    check({tag, "_mdata"}, 32'(bus.mem_data),         32'd0);
    check({tag, "_mwr"},   32'(bus.mem_wr),           32'd0);
    check({tag, "_cip"},   32'(bus.copy_in_progress), 32'd0);
    check({tag, "_req"},   32'(bus.cpu_reset_req),    32'd0);
    check({tag, "_bytes"}, 32'(bus.bytes_loaded),     32'd0);
    check({tag, "_ovf"},   32'(bus.overflow),         32'd0);
  endtask

  task automatic start_dl(input logic [7:0] idx, input logic active);
    @(negedge clk);
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = idx;
    @(negedge clk);
    bus.ioctl_download = 1'b1;
    if (active) begin
      exp_bytes = 0;
      exp_ovf   = 1'b0;
    end
    @(negedge clk);
    check("start_cip", 32'(bus.copy_in_progress), 32'(active));
    check("start_req", 32'(bus.cpu_reset_req),    32'(active));
  endtask

  task automatic send_word(input logic [24:0] a, input logic [15:0] d, input logic active);
    @(negedge clk);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
    check("wait_lo", 32'(bus.ioctl_wait), 32'(active));
    @(negedge clk);
    check("wait_hi", 32'(bus.ioctl_wait), 32'(active));
    @(negedge clk);
    check("wait_end", 32'(bus.ioctl_wait), 32'd0);
    if (active) model_word(a, d);
  endtask

  task automatic end_dl(input logic active);
    @(negedge clk);
    bus.ioctl_download = 1'b0;
    @(negedge clk);
    check("hold_cip", 32'(bus.copy_in_progress), 32'd0);
    check("hold_req", 32'(bus.cpu_reset_req),    32'(active));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.cpu_reset_req && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n < 2000), 32'd1);
  endtask

  initial begin
    int          hold_n;
    bit          done;
    logic [7:0]  idx;
    logic        act;
    logic [24:0] a;
    int          sel;

    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    exp_bytes          = 0;
    exp_ovf            = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic two-word load
    start_dl(8'd0, 1'b1);
    send_word(25'd0, 16'h3E01, 1'b1);
    send_word(25'd2, 16'hD376, 1'b1);
    end_dl(1'b1);
    compare_writes("basic");
    check_status("basic");
    check("basic_bytes_const", 32'(bus.bytes_loaded), 32'd4);
    wait_idle("basic");

    // Foreign index: nothing changes
    start_dl(8'd1, 1'b0);
    for (int i = 0; i < 3; i++) send_word(25'(2 * i), 16'($urandom), 1'b0);
    check("foreign_cip", 32'(bus.copy_in_progress), 32'd0);
    check("foreign_req", 32'(bus.cpu_reset_req),    32'd0);
    end_dl(1'b0);
    compare_writes("foreign");
    check_status("foreign");

    // Top-of-memory boundary then out-of-range word
    start_dl(8'd0, 1'b1);
    send_word(25'h0FFE, 16'hBBAA, 1'b1);
    send_word(25'h1000, 16'h2211, 1'b1);
    end_dl(1'b1);
    compare_writes("boundary");
    check_status("boundary");

    // Restart from HOLD, then download falls with the last strobe
    start_dl(8'd0, 1'b1);
    check_status("restart");
    send_word(25'h10, 16'h5A5A, 1'b1);
    @(negedge clk);
    bus.ioctl_wr       = 1'b1;
    bus.ioctl_addr     = 25'h50;
    bus.ioctl_dout     = 16'h7788;
    bus.ioctl_download = 1'b0;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
    check("lastwr_lo", 32'(bus.mem_wr), 32'd1);
    @(negedge clk);
    check("lastwr_hi", 32'(bus.mem_wr), 32'd1);
    model_word(25'h50, 16'h7788);
    @(negedge clk);
    check("lastwr_hold_cip", 32'(bus.copy_in_progress), 32'd0);
    hold_n = 0;
    done   = 1'b0;
    if (bus.cpu_reset_req) hold_n = 1; else done = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (bus.cpu_reset_req) hold_n++; else done = 1'b1;
    end
    check("hold_len", 32'(hold_n), 32'(HOLD_CYC));
    check("hold_done_req", 32'(bus.cpu_reset_req), 32'd0);
    compare_writes("lastwr");
    check_status("lastwr");

    // Strobe during WR_HI is ignored
    start_dl(8'd0, 1'b1);
    @(negedge clk);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'h30;
    bus.ioctl_dout = 16'hCAFE;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
    check("dblwr_wait_lo", 32'(bus.ioctl_wait), 32'd1);
    @(negedge clk);
    check("dblwr_wait_hi", 32'(bus.ioctl_wait), 32'd1);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'h40;
    bus.ioctl_dout = 16'h9999;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
    check("dblwr_wait_drop", 32'(bus.ioctl_wait), 32'd0);
    @(negedge clk);
    check("dblwr_wait_stay", 32'(bus.ioctl_wait), 32'd0);
    model_word(25'h30, 16'hCAFE);
    end_dl(1'b1);
    compare_writes("dblwr");
    check_status("dblwr");

    // Reset in the middle of a word
    start_dl(8'd0, 1'b1);
    send_word(25'd0, 16'h1234, 1'b1);
    @(negedge clk);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'd2;
    bus.ioctl_dout = 16'hBEEF;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
    check("midrst_lo", 32'(bus.mem_wr), 32'd1);
    exp_q.push_back({12'd2, 8'hEF});
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    repeat (3) @(negedge clk);
    compare_writes("midrst");
    exp_bytes = 0;
    exp_ovf   = 1'b0;
    rst_n     = 1'b1;
    repeat (4) @(negedge clk);
    check("held_dl_cip", 32'(bus.copy_in_progress), 32'd0);
    check("held_dl_req", 32'(bus.cpu_reset_req),    32'd0);
    start_dl(8'd0, 1'b1);
    send_word(25'd8,  16'h4321, 1'b1);
    send_word(25'd10, 16'h8765, 1'b1);
    end_dl(1'b1);
    compare_writes("postrst");
    check_status("postrst");

    // Fill the whole memory plus one word: count saturates
    start_dl(8'd0, 1'b1);
    for (int i = 0; i < int'(MEM_BYTES / 2); i++)
      send_word(25'(2 * i), 16'($urandom), 1'b1);
    send_word(25'd0, 16'h0F0F, 1'b1);
    end_dl(1'b1);
    compare_writes("sat");
    check_status("sat");
    check("sat_bytes_const", 32'(bus.bytes_loaded), 32'd4096);

    // Randomized downloads
    for (int r = 0; r < 6; r++) begin
      idx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      act = (idx == 8'd0);
      if (!act) wait_idle("rand");
      start_dl(idx, act);
      for (int w = 0; w < int'($urandom_range(3, 8)); w++) begin
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      a = 25'h0FFE;
        else if (sel == 1) a = 25'(MEM_BYTES + 2 * $urandom_range(0, 100));
        else               a = 25'(2 * $urandom_range(0, 2047));
        send_word(a, 16'($urandom), act);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      end_dl(act);
      compare_writes($sformatf("rand%0d", r));
      check_status($sformatf("rand%0d", r));
    end

    wait_idle("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
